// File: rtl/spi_write_nbit.sv
// spi_write_nbit - parametrised SPI-style write/read engine.
// Generates its own csn/sclk, shifts a WIDTH-bit word out on mosi and
// captures a WIDTH-bit return word from miso (sclk idle low, mosi changes
// on the falling edge, miso sampled on the rising edge).
// Ports:
//   clk_i, rstn_i      system clock, synchronous active-low reset
//   start_i, data_in_i transfer request and word to send (sampled on accept)
//   miso_i             serial return data
//   csn_o, sclk_o      chip select (active low), serial clock
//   mosi_o             serial transmit data
//   busy_o, done_o     transfer in progress, one-cycle completion pulse
//   data_rx_o          last complete received word
module spi_write_nbit #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             miso_i,
  output logic             csn_o,
  output logic             sclk_o,
  output logic             mosi_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_rx_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] data_rx_q, data_rx_d;

  logic             tick;
  logic             last_bit;
  logic [WIDTH-1:0] tx_next;
  logic [WIDTH-1:0] rx_next;

  assign tick     = (cnt_q == CW'(DIV - 1));
  assign last_bit = (bits_q == BW'(WIDTH));

  // Shift direction follows bit order: the bit on the wire is always the
  // tx_q end that leaves first, and the first received bit ends up at the
  // matching end of rx_q after WIDTH shifts.
  assign tx_next = MSB_FIRST ? {tx_q[WIDTH-2:0], 1'b0} : {1'b0, tx_q[WIDTH-1:1]};
  assign rx_next = MSB_FIRST ? {rx_q[WIDTH-2:0], miso_i} : {miso_i, rx_q[WIDTH-1:1]};

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      sclk_q    <= sclk_d;
      done_q    <= done_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    bits_d    = bits_q;
    sclk_d    = sclk_q;
    done_d    = 1'b0;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (start_i) begin
          tx_d    = data_in_i;
          rx_d    = '0;
          bits_d  = '0;
          state_d = SETUP;
        end
      end
      // Chip-select setup: sclk low for DIV cycles, then the first rise.
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          rx_d    = rx_next;
          bits_d  = BW'(1);
        end
      end
      // Each sclk period is DIV high then DIV low. The low half after the
      // last bit completes the final period before HOLD starts.
      SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (!last_bit) tx_d = tx_next;
          end else if (last_bit) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
            rx_d   = rx_next;
            bits_d = bits_q + BW'(1);
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          data_rx_d = rx_q;
          tx_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q != IDLE);
  assign csn_o     = (state_q == IDLE);
  assign sclk_o    = sclk_q;
  assign mosi_o    = busy_o & (MSB_FIRST ? tx_q[WIDTH-1] : tx_q[0]);
  assign done_o    = done_q;
  assign data_rx_o = data_rx_q;

endmodule
